// File: rtl/conv3x3_mac_rgb888.sv
// Per-channel 3x3 convolution of one captured RGB888 window, one tap per cycle, then round/shift/clamp and BRAM write.
// Latency: valid sampled at edge T -> 9 MAC cycles, 1 ROUND cycle, oWe during T+11; one pixel per 12 cycles minimum.
// Backpressure: oBusy (combinational, state != IDLE) stalls the window generator; iEn=0 freezes all state and masks oWe/oDone.
module conv3x3_mac_rgb888 #(
  parameter int DATA_W = 24,
  parameter int COEF_W = 8,
  parameter int SHIFT  = 0,
  parameter int ADDR_W = 17,
  parameter int DEPTH  = 130560
) (
  input  logic                     iClk,
  input  logic                     iRst,
  input  logic                     iEn,
  input  logic                     iStart,
  input  logic                     iValid,
  input  logic [DATA_W-1:0]        iPix0,
  input  logic [DATA_W-1:0]        iPix1,
  input  logic [DATA_W-1:0]        iPix2,
  input  logic [DATA_W-1:0]        iPix3,
  input  logic [DATA_W-1:0]        iPix4,
  input  logic [DATA_W-1:0]        iPix5,
  input  logic [DATA_W-1:0]        iPix6,
  input  logic [DATA_W-1:0]        iPix7,
  input  logic [DATA_W-1:0]        iPix8,
  input  logic signed [COEF_W-1:0] iK0,
  input  logic signed [COEF_W-1:0] iK1,
  input  logic signed [COEF_W-1:0] iK2,
  input  logic signed [COEF_W-1:0] iK3,
  input  logic signed [COEF_W-1:0] iK4,
  input  logic signed [COEF_W-1:0] iK5,
  input  logic signed [COEF_W-1:0] iK6,
  input  logic signed [COEF_W-1:0] iK7,
  input  logic signed [COEF_W-1:0] iK8,
  output logic                     oBusy,
  output logic                     oWe,
  output logic [ADDR_W-1:0]        oAddr,
  output logic [DATA_W-1:0]        oPixel,
  output logic                     oDone
);

  // Accumulator holds 9 taps of (9-bit unsigned x COEF_W signed) with headroom, so it never overflows.
  localparam int ACC_W  = COEF_W + 13;
  localparam int PROD_W = COEF_W + 9;
  localparam logic signed [ACC_W-1:0] RND  = ACC_W'((1 << SHIFT) >> 1);
  localparam logic signed [ACC_W-1:0] MAX8 = ACC_W'(255);
  localparam logic [ADDR_W-1:0]       LAST = ADDR_W'(DEPTH - 1);

  typedef enum logic [1:0] {IDLE, MAC, ROUND, WRITE} state_t;

  state_t                   state;
  logic [3:0]               tapK;
  logic [DATA_W-1:0]        pixReg [9];
  logic signed [COEF_W-1:0] kReg   [9];
  logic signed [ACC_W-1:0]  acc    [3];
  logic signed [PROD_W-1:0] prod   [3];
  logic [DATA_W-1:0]        curPix;
  logic signed [COEF_W-1:0] curK;

  // Round half-up, arithmetic shift, then saturate to an unsigned byte.
  function automatic logic [7:0] clampByte(input logic signed [ACC_W-1:0] a);
    logic signed [ACC_W-1:0] s;
    s = (a + RND) >>> SHIFT;
    if (s[ACC_W-1])    return 8'd0;
    else if (s > MAX8) return 8'hFF;
    else               return s[7:0];
  endfunction

  // Products for the current tap: zero-extended channel byte times sign-extended coefficient.
  always_comb begin
    curPix = pixReg[tapK];
    curK   = kReg[tapK];
    for (int c = 0; c < 3; c++) begin
      prod[c] = $signed({{(PROD_W-8){1'b0}}, curPix[8*c +: 8]}) *
                $signed({{(PROD_W-COEF_W){curK[COEF_W-1]}}, curK});
    end
  end

  // Handshake and write strobes; writes are masked while disabled so a stalled WRITE is not duplicated.
  always_comb begin
    oBusy = (state != IDLE);
    oWe   = (state == WRITE) && iEn;
    oDone = oWe && (oAddr == LAST);
  end

  // Main sequencer: capture, 9-tap MAC, round/clamp into oPixel, then advance the write address.
  always_ff @(posedge iClk or negedge iRst) begin
    if (!iRst) begin
      state  <= IDLE;
      tapK   <= '0;
      oAddr  <= '0;
      oPixel <= '0;
      for (int i = 0; i < 9; i++) begin
        pixReg[i] <= '0;
        kReg[i]   <= '0;
      end
      for (int c = 0; c < 3; c++) acc[c] <= '0;
    end else if (iEn) begin
      case (state)
        IDLE: begin
          if (iStart) oAddr <= '0;
          if (iValid) begin
            pixReg[0] <= iPix0; pixReg[1] <= iPix1; pixReg[2] <= iPix2;
            pixReg[3] <= iPix3; pixReg[4] <= iPix4; pixReg[5] <= iPix5;
            pixReg[6] <= iPix6; pixReg[7] <= iPix7; pixReg[8] <= iPix8;
            kReg[0] <= iK0; kReg[1] <= iK1; kReg[2] <= iK2;
            kReg[3] <= iK3; kReg[4] <= iK4; kReg[5] <= iK5;
            kReg[6] <= iK6; kReg[7] <= iK7; kReg[8] <= iK8;
            tapK  <= '0;
            for (int c = 0; c < 3; c++) acc[c] <= '0;
            state <= MAC;
          end
        end
        MAC: begin
          for (int c = 0; c < 3; c++) begin
            acc[c] <= acc[c] + {{(ACC_W-PROD_W){prod[c][PROD_W-1]}}, prod[c]};
          end
          if (tapK == 4'd8) begin
            tapK  <= '0;
            state <= ROUND;
          end else begin
            tapK <= tapK + 4'd1;
          end
        end
        ROUND: begin
          oPixel <= {clampByte(acc[2]), clampByte(acc[1]), clampByte(acc[0])};
          state  <= WRITE;
        end
        WRITE: begin
          oAddr <= (oAddr == LAST) ? '0 : oAddr + 1'b1;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_conv3x3_mac_rgb888.sv
// Directed bench for conv3x3_mac_rgb888 with DEPTH=4; a second SHIFT=1 instance shares the stimulus for rounding.
// Latency: checks the write strobe lands exactly 10 edges after the capture edge (15 with a 5-cycle enable gap).
// Backpressure: checks oBusy stays high from capture through the write and drops the following cycle.
module tb_conv3x3_mac_rgb888;

  logic              iClk = 1'b0;
  logic              iRst = 1'b0;
  logic              iEn = 1'b1;
  logic              iStart = 1'b0;
  logic              iValid = 1'b0;
  logic [23:0]       pix [9];
  logic signed [7:0] kc  [9];

  logic        oBusy, oWe, oDone;
  logic [16:0] oAddr;
  logic [23:0] oPixel;
  logic        busyR, weR, doneR;
  logic [16:0] addrR;
  logic [23:0] pixelR;

  int nTests = 0;
  int nFail  = 0;

  int          gotLat;
  int          busyErr;
  logic [23:0] gotPix, gotPixR;
  logic [16:0] gotAddr;
  logic        gotDone, afterWe, afterBusy;

  always #5 iClk = ~iClk;

  conv3x3_mac_rgb888 #(.SHIFT(0), .DEPTH(4)) dut (
    .iClk(iClk), .iRst(iRst), .iEn(iEn), .iStart(iStart), .iValid(iValid),
    .iPix0(pix[0]), .iPix1(pix[1]), .iPix2(pix[2]), .iPix3(pix[3]), .iPix4(pix[4]),
    .iPix5(pix[5]), .iPix6(pix[6]), .iPix7(pix[7]), .iPix8(pix[8]),
    .iK0(kc[0]), .iK1(kc[1]), .iK2(kc[2]), .iK3(kc[3]), .iK4(kc[4]),
    .iK5(kc[5]), .iK6(kc[6]), .iK7(kc[7]), .iK8(kc[8]),
    .oBusy(oBusy), .oWe(oWe), .oAddr(oAddr), .oPixel(oPixel), .oDone(oDone)
  );

  conv3x3_mac_rgb888 #(.SHIFT(1), .DEPTH(4)) dutR (
    .iClk(iClk), .iRst(iRst), .iEn(iEn), .iStart(iStart), .iValid(iValid),
    .iPix0(pix[0]), .iPix1(pix[1]), .iPix2(pix[2]), .iPix3(pix[3]), .iPix4(pix[4]),
    .iPix5(pix[5]), .iPix6(pix[6]), .iPix7(pix[7]), .iPix8(pix[8]),
    .iK0(kc[0]), .iK1(kc[1]), .iK2(kc[2]), .iK3(kc[3]), .iK4(kc[4]),
    .iK5(kc[5]), .iK6(kc[6]), .iK7(kc[7]), .iK8(kc[8]),
    .oBusy(busyR), .oWe(weR), .oAddr(addrR), .oPixel(pixelR), .oDone(doneR)
  );

  task automatic checkEq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nTests++;
    if (got !== exp) begin
      nFail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic setWin(input logic [23:0] p, input logic signed [7:0] k);
    for (int i = 0; i < 9; i++) begin
      pix[i] = p;
      kc[i]  = k;
    end
  endtask

  // Identity kernel around a given centre pixel, random neighbours.
  task automatic setIdent(input logic [23:0] centre);
    for (int i = 0; i < 9; i++) begin
      pix[i] = 24'($urandom);
      kc[i]  = 8'sd0;
    end
    pix[4] = centre;
    kc[4]  = 8'sd1;
  endtask

  // Pulse valid, then wait (bounded) for the write; optional 5-cycle enable gap after edge gapAt.
  task automatic runWindow(input int gapAt);
    gotLat  = -1;
    busyErr = 0;
    @(negedge iClk); iValid = 1'b1;
    @(posedge iClk); #1; iValid = 1'b0;
    pix[4] = 24'h0F0F0F;
    kc[4]  = 8'sd3;
    if (!oBusy) busyErr++;
    for (int n = 1; n <= 40; n++) begin
      @(posedge iClk); #1;
      if (n == gapAt)     iEn = 1'b0;
      if (n == gapAt + 5) iEn = 1'b1;
      if (oWe) begin
        gotLat  = n;
        gotPix  = oPixel;
        gotPixR = pixelR;
        gotAddr = oAddr;
        gotDone = oDone;
        break;
      end
      if (!oBusy) busyErr++;
    end
    @(posedge iClk); #1;
    afterWe   = oWe;
    afterBusy = oBusy;
  endtask

  task automatic checkWin(input string tag, input int lat, input logic [23:0] expPix,
                          input logic [16:0] expAddr, input logic expDone);
    checkEq({tag, ".lat"},   gotLat, lat);
    checkEq({tag, ".pix"},   gotPix, expPix);
    checkEq({tag, ".addr"},  gotAddr, expAddr);
    checkEq({tag, ".done"},  gotDone, expDone);
    checkEq({tag, ".busy"},  busyErr, 0);
    checkEq({tag, ".weOff"}, afterWe, 1'b0);
    checkEq({tag, ".idle"},  afterBusy, 1'b0);
  endtask

  initial begin
    int weCount;
    setWin(24'h0, 8'sd0);
    #12;
    checkEq("rst.busy", oBusy, 1'b0);
    checkEq("rst.we", oWe, 1'b0);
    checkEq("rst.addr", oAddr, 17'd0);
    checkEq("rst.pixel", oPixel, 24'd0);
    checkEq("rst.done", oDone, 1'b0);
    @(negedge iClk); iRst = 1'b1;

    @(negedge iClk); iStart = 1'b1;
    @(negedge iClk); iStart = 1'b0;

    // Identity: 0x12/0x34/0x56 pass through; SHIFT=1 gives (x+1)>>1 = 09/1A/2B.
    setIdent(24'h123456);
    runWindow(-100);
    checkWin("ident", 10, 24'h123456, 17'd0, 1'b0);
    checkEq("ident.shift1", gotPixR, 24'h091A2B);

    // All ones: 9*0x10 = 0x90 per channel.
    setWin(24'h101010, 8'sd1);
    runWindow(-100);
    checkWin("sum9", 10, 24'h909090, 17'd1, 1'b0);

    // 9*0x20 = 288 saturates.
    setWin(24'h202020, 8'sd1);
    runWindow(-100);
    checkWin("clampHi", 10, 24'hFFFFFF, 17'd2, 1'b0);

    // Negative centre tap: 0, -0x80, -0xFF all clamp to 0; last address -> done.
    setWin(24'hFFFFFF, 8'sd0);
    pix[4] = 24'h0080FF;
    kc[4]  = -8'sd1;
    runWindow(-100);
    checkWin("clampLo", 10, 24'h000000, 17'd3, 1'b1);

    // Sum 3 per channel: SHIFT=0 -> 3, SHIFT=1 -> (3+1)>>1 = 2; address wraps to 0.
    setWin(24'h0, 8'sd0);
    for (int i = 0; i < 3; i++) begin
      pix[i] = 24'h010101;
      kc[i]  = 8'sd1;
    end
    runWindow(-100);
    checkWin("round", 10, 24'h030303, 17'd0, 1'b0);
    checkEq("round.shift1", gotPixR, 24'h020202);

    // Enable low for 5 cycles mid-MAC: 9*(05,04,03) = 2D,24,1B, write 5 edges later.
    setWin(24'h050403, 8'sd1);
    runWindow(3);
    checkWin("enGap", 15, 24'h2D241B, 17'd1, 1'b0);

    // Reset during ROUND: outputs return to reset values, no write follows.
    setIdent(24'hABCDEF);
    @(negedge iClk); iValid = 1'b1;
    @(posedge iClk); #1; iValid = 1'b0;
    for (int n = 1; n <= 9; n++) begin
      @(posedge iClk); #1;
    end
    checkEq("preRst.busy", oBusy, 1'b1);
    iRst = 1'b0;
    #1;
    checkEq("midRst.busy", oBusy, 1'b0);
    checkEq("midRst.we", oWe, 1'b0);
    checkEq("midRst.addr", oAddr, 17'd0);
    checkEq("midRst.pixel", oPixel, 24'd0);
    checkEq("midRst.done", oDone, 1'b0);
    @(negedge iClk); iRst = 1'b1;
    weCount = 0;
    for (int n = 0; n < 15; n++) begin
      @(posedge iClk); #1;
      if (oWe) weCount++;
    end
    checkEq("midRst.noWrite", weCount, 0);

    setIdent(24'h445566);
    runWindow(-100);
    checkWin("postRst", 10, 24'h445566, 17'd0, 1'b0);

    $display("[TB] %0d tests run, %0d failed", nTests, nFail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1);
  end

endmodule

// File: doc/conv3x3_mac_rgb888.md
# conv3x3_mac_rgb888

Downstream consumer of the 3x3 RGB888 window generator. It captures one 9-pixel window per valid pulse and runs a per-channel 3x3 convolution as a sequential multiply-accumulate, one tap per cycle. It then rounds, shifts and clamps each channel to 8 bits and writes the result pixel to an output frame BRAM at a linearly incrementing address. Its busy output stalls the window generator while a window is in flight.

## Interface
- DATA_W, 24, pixel width, {R[23:16], G[15:8], B[7:0]}
- COEF_W, 8, signed coefficient width
- SHIFT, 0, right shift applied to each channel sum before clamping (0..15)
- ADDR_W, 17, output BRAM address width
- DEPTH, 130560, output pixels per frame (WIDTH*HEIGHT)

Ports:
- iClk  in  1  clock
- iRst  in  1  asynchronous, active-low reset
- iEn  in  1  global enable; when 0, all state and outputs freeze
- iStart  in  1  frame start; clears the write address when idle
- iValid  in  1  window valid pulse
- iPix0..iPix8  in  DATA_W each  window pixels, row-major, iPix4 = centre
- iK0..iK8  in  COEF_W each  signed kernel coefficients, index matches iPix
- oBusy  out  1  high while a window is being processed
- oWe  out  1  BRAM write strobe / chip select
- oAddr  out  ADDR_W  BRAM write address
- oPixel  out  DATA_W  BRAM write data
- oDone  out  1  one-cycle pulse on the write of address DEPTH-1

## Operation
- States: IDLE, MAC, ROUND, WRITE. All transitions require iEn=1.
- IDLE:
  - iStart=1 sets the address counter to 0.
  - iValid=1 captures iPix0..8 and iK0..8 into internal registers, clears the tap counter k and the three accumulators, and moves to MAC.
  - If iStart and iValid arrive together, the clear is applied first and the capture proceeds.
- MAC: lasts exactly 9 cycles, k = 0..8.
  - Each channel c computes acc_c += zero_extend(pix[k].c) * K[k].
  - The product is signed: 9-bit zero-extended pixel times COEF_W signed coefficient.
  - Accumulators are signed, ACC_W = COEF_W+13 bits. They cannot overflow.
  - After k=8, go to ROUND.
- ROUND: for each channel, r = (acc + (SHIFT>0 ? 1<<(SHIFT-1) : 0)) >>> SHIFT (arithmetic shift).
  - Clamp: r<0 gives 0, r>255 gives 255.
  - The result registers into oPixel. Go to WRITE.
- WRITE:
  - oWe=1 for one cycle with the current address on oAddr.
  - oDone=1 in the same cycle if the address is DEPTH-1.
  - Next cycle: the address increments, wrapping from DEPTH-1 to 0. Return to IDLE.
- iValid while oBusy=1 is ignored. The upstream block gates valid with !busy, so this does not occur in-system.
- iPix and iK changes after capture have no effect on the window in flight.

## Timing
- Reset values: state IDLE, oBusy 0, oWe 0, oAddr 0, oPixel 0, oDone 0, accumulators 0, k 0.
- oBusy is combinational: (state != IDLE). It rises in the cycle after capture, which the upstream block sees before its next valid slot.
- Valid sampled at edge T (the rising edge where iValid=1 is registered):
  - MAC covers cycles T+1..T+9.
  - ROUND at T+10.
  - oWe high during T+11 with oPixel and oAddr valid.
  - oBusy low again from T+12.
- Throughput: one pixel per 12 cycles minimum.
- iEn=0 on any cycle: no state, counter, accumulator or output register updates. oWe and oDone are forced to 0 while iEn=0. Latency stretches by the number of disabled cycles.
- The WRITE strobe is never duplicated. If iEn drops during WRITE, oWe is low that cycle and reasserts when iEn returns.
- Reset asserted mid-operation: immediate return to the reset values. The window in flight is discarded and no write occurs.
- oPixel holds its last value between writes.

## Test plan
- Identity kernel (K4=1, others 0), SHIFT=0, iPix4=0x123456, others random, valid at T → oWe=1 at T+11, oPixel=0x123456, oAddr=0, oBusy high T+1..T+11.
- All K=1, SHIFT=0, all pixels 0x101010 → oPixel=0x909090. The same window with all pixels 0x202020 → 0xFFFFFF (clamp high).
- K4=-1, others 0, iPix4=0x0080FF → oPixel=0x000000 (clamp low, negative sums).
- Rounding: SHIFT=1, K0=K1=K2=1, pixels 0..2 = 0x010101, others 0 → sum 3, result 0x020202.
- DEPTH=4, iStart then 5 windows → addresses 0,1,2,3,0. oDone pulses only on the address-3 write.
- iEn held low 5 cycles during MAC → write at T+16 with the correct value. Reset pulse during ROUND → no write; all outputs 0; the next window writes to address 0.
